// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// ID control-bit positions and the controller's per-cycle operating mode.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CTRL_W        = 3;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_BRANCH   = 2;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_FLUSH = 2'd1,
    MODE_STALL = 2'd2,
    MODE_HOLD  = 2'd3
  } ctrl_mode_e;

  // There is no memwrite bit: a real, non-branch instruction that writes no register is a store.
  function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD] | (~ctrl[CTRL_REGWRITE] & ~ctrl[CTRL_BRANCH]);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source operand against the EX/MEM/WB shadow records and
// produces its forwarding select plus the dependency flags used for stalling.
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] src,
  input  logic           used,
  input  logic           ex_valid,
  input  logic [RAW-1:0] ex_rd,
  input  logic           ex_regwrite,
  input  logic           ex_memread,
  input  logic           mem_valid,
  input  logic [RAW-1:0] mem_rd,
  input  logic           mem_regwrite,
  input  logic           mem_memread,
  input  logic           wb_valid,
  input  logic [RAW-1:0] wb_rd,
  input  logic           wb_regwrite,
  output logic [1:0]     fwd,
  output logic           ex_hit,
  output logic           ex_load_hit,
  output logic           mem_load_hit
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired, so a write to it never produces a usable value.
  assign ex_hit  = used & ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == src);
  assign mem_hit = used & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == src);
  assign wb_hit  = used & wb_valid  & wb_regwrite  & (wb_rd  != '0) & (wb_rd  == src);

  assign ex_load_hit  = ex_hit & ex_memread;
  assign mem_load_hit = mem_hit & mem_memread;

  always_comb begin
    fwd = FWD_RF;
    if (mem_hit) begin
      fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks EX/MEM/WB shadow records,
// drives stall/flush/hold controls, forwarding selects and a stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int RAW     = 5,
  parameter int CNT_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  input  logic [NUM_SRC*RAW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]     id_rs_used_i,
  input  logic [RAW-1:0]         id_rd_i,
  input  logic [CTRL_W-1:0]      id_ctrl_i,
  input  logic                   branch_taken_i,
  input  logic                   dmem_ready_i,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   ifid_flush_o,
  output logic                   idex_bubble_o,
  output logic                   pipe_hold_o,
  output logic [NUM_SRC*2-1:0]   ex_fwd_o,
  output logic [NUM_SRC*2-1:0]   id_fwd_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  logic           ex_valid, ex_regwrite, ex_memread, ex_memop;
  logic [RAW-1:0] ex_rd;
  logic           mem_valid, mem_regwrite, mem_memread, mem_memop;
  logic [RAW-1:0] mem_rd;
  logic           wb_valid, wb_regwrite;
  logic [RAW-1:0] wb_rd;

  logic [NUM_SRC-1:0]   ex_hit;
  logic [NUM_SRC-1:0]   ex_load_hit;
  logic [NUM_SRC-1:0]   mem_load_hit;
  logic [NUM_SRC*2-1:0] fwd_sel;

  logic       id_branch;
  logic       hazard;
  logic       mem_wait;
  ctrl_mode_e mode;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_match #(
      .RAW(RAW)
    ) u_match (
      .src          (id_rs_i[k*RAW +: RAW]),
      .used         (id_rs_used_i[k]),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .mem_memread  (mem_memread),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd          (fwd_sel[k*2 +: 2]),
      .ex_hit       (ex_hit[k]),
      .ex_load_hit  (ex_load_hit[k]),
      .mem_load_hit (mem_load_hit[k])
    );
  end

  assign id_branch = id_ctrl_i[CTRL_BRANCH];
  assign hazard    = id_valid_i & ((|ex_load_hit) | (id_branch & ((|ex_hit) | (|mem_load_hit))));
  assign mem_wait  = mem_valid & mem_memop & ~dmem_ready_i;

  // Priority: memory wait freezes everything, then dependency stall, then branch flush.
  always_comb begin
    mode = MODE_RUN;
    if (rst_i) begin
      mode = MODE_RUN;
    end else if (mem_wait) begin
      mode = MODE_HOLD;
    end else if (hazard) begin
      mode = MODE_STALL;
    end else if (id_valid_i & id_branch & branch_taken_i) begin
      mode = MODE_FLUSH;
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    case (mode)
      MODE_HOLD: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        pipe_hold_o  = 1'b1;
      end
      MODE_STALL: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      MODE_FLUSH: ifid_flush_o = 1'b1;
      default: ;
    endcase
  end

  assign ex_fwd_o = fwd_sel;
  assign id_fwd_o = fwd_sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memop     <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memop    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (mode != MODE_HOLD) begin
      ex_valid     <= id_valid_i & (mode != MODE_STALL);
      ex_rd        <= id_rd_i;
      ex_regwrite  <= id_ctrl_i[CTRL_REGWRITE];
      ex_memread   <= id_ctrl_i[CTRL_MEMREAD];
      ex_memop     <= is_mem_op(id_ctrl_i);
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      mem_memop    <= ex_memop;
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (((mode == MODE_STALL) || (mode == MODE_HOLD)) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a stage model.
module tb_pipe_hazard_ctrl;

  localparam int NUM_SRC = 2;
  localparam int RAW     = 5;
  localparam int CNT_W   = 4;
  localparam logic [12:0] IDLE = 13'b11000_0000_0000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   id_valid;
  logic [NUM_SRC*RAW-1:0] id_rs;
  logic [NUM_SRC-1:0]     id_rs_used;
  logic [RAW-1:0]         id_rd;
  logic [2:0]             id_ctrl;
  logic                   branch_taken;
  logic                   dmem_ready;
  logic                   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [NUM_SRC*2-1:0]   ex_fwd, id_fwd;
  logic [CNT_W-1:0]       stall_cnt;
  logic [12:0]            dut_out;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .NUM_SRC(NUM_SRC),
    .RAW    (RAW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rs_used_i  (id_rs_used),
    .id_rd_i       (id_rd),
    .id_ctrl_i     (id_ctrl),
    .branch_taken_i(branch_taken),
    .dmem_ready_i  (dmem_ready),
    .pc_write_o    (pc_write),
    .ifid_write_o  (ifid_write),
    .ifid_flush_o  (ifid_flush),
    .idex_bubble_o (idex_bubble),
    .pipe_hold_o   (pipe_hold),
    .ex_fwd_o      (ex_fwd),
    .id_fwd_o      (id_fwd),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  assign dut_out = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, ex_fwd, id_fwd};

  typedef struct {
    logic        valid;
    logic [9:0]  rs;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic        taken;
    logic        ready;
    logic [12:0] exp_out;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[18];
  vec_t seq[7];

  function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                              input logic [1:0] used, input logic [4:0] rd, input logic [2:0] ctrl,
                              input logic tk, input logic rdy, input logic [12:0] eo, input logic [3:0] ec);
    vec_t r;
    r.valid = v; r.rs = {s1, s0}; r.used = used; r.rd = rd; r.ctrl = ctrl;
    r.taken = tk; r.ready = rdy; r.exp_out = eo; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [9:0] rs, input logic [1:0] used,
                               input logic [4:0] rd, input logic [2:0] ctrl, input logic tk, input logic rdy);
    id_valid     = v;
    id_rs        = rs;
    id_rs_used   = used;
    id_rd        = rd;
    id_ctrl      = ctrl;
    branch_taken = tk;
    dmem_ready   = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v.valid, v.rs, v.used, v.rd, v.ctrl, v.taken, v.ready);
    #2;
    checkOutput({name, "_out"}, 32'(dut_out), 32'(v.exp_out));
    checkOutput({name, "_cnt"}, 32'(stall_cnt), 32'(v.exp_cnt));
    nextCycle();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  // Stage model: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    bit store;
  } rec_t;

  rec_t st[3];
  int   mcnt;

  function automatic bit writes(input rec_t r, input int src, input bit used);
    return used && r.v && r.rw && r.rd != 0 && r.rd == src;
  endfunction

  task automatic modelStep(output logic [12:0] exp_o);
    int  src[2];
    bit  used[2];
    int  f[2];
    bit  hold, stall, flush, dep, br;
    br = id_ctrl[2];
    dep = 0;
    for (int k = 0; k < 2; k++) begin
      src[k]  = int'(id_rs[k*RAW +: RAW]);
      used[k] = id_rs_used[k];
      f[k] = writes(st[1], src[k], used[k]) ? 2 : (writes(st[2], src[k], used[k]) ? 1 : 0);
      if (writes(st[0], src[k], used[k]) && (st[0].mr || br)) dep = 1;
      if (br && writes(st[1], src[k], used[k]) && st[1].mr) dep = 1;
    end
    hold  = st[1].v && (st[1].mr || st[1].store) && !dmem_ready;
    stall = !hold && id_valid && dep;
    flush = !hold && !stall && id_valid && br && branch_taken;
    exp_o = {!(hold || stall), !(hold || stall), flush, stall, hold,
             2'(f[1]), 2'(f[0]), 2'(f[1]), 2'(f[0])};
    if (!hold) begin
      st[2] = st[1];
      st[1] = st[0];
      st[0].v     = id_valid && !stall;
      st[0].rd    = int'(id_rd);
      st[0].rw    = id_ctrl[0];
      st[0].mr    = id_ctrl[1];
      st[0].store = (id_ctrl == 3'b000);
    end
    if ((hold || stall) && mcnt < 15) mcnt++;
  endtask

  initial begin
    logic [12:0] exp_o;
    logic [2:0]  ops[4];
    ops[0] = 3'b011; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b000;

    // lw=011, add=001, beq=100, sw=000
    vecs[0]  = mk(1, 0, 1, 2'b01, 5, 3'b011, 0, 1, IDLE, 0);
    vecs[1]  = mk(1, 2, 5, 2'b11, 6, 3'b001, 0, 1, 13'b00010_0000_0000, 0);
    vecs[2]  = mk(1, 2, 5, 2'b11, 6, 3'b001, 0, 1, 13'b11000_0010_0010, 1);
    vecs[3]  = mk(1, 0, 0, 2'b00, 3, 3'b001, 0, 1, IDLE, 1);
    vecs[4]  = mk(1, 0, 0, 2'b00, 3, 3'b001, 0, 1, IDLE, 1);
    vecs[5]  = mk(0, 0, 0, 2'b00, 0, 3'b000, 0, 1, IDLE, 1);
    vecs[6]  = mk(1, 3, 3, 2'b11, 0, 3'b001, 0, 1, 13'b11000_1010_1010, 1);
    vecs[7]  = mk(1, 0, 3, 2'b01, 7, 3'b001, 0, 1, 13'b11000_0001_0001, 1);
    vecs[8]  = mk(1, 0, 0, 2'b11, 8, 3'b001, 0, 1, IDLE, 1);
    vecs[9]  = mk(1, 2, 1, 2'b11, 0, 3'b100, 1, 1, 13'b11100_0000_0000, 1);
    vecs[10] = mk(0, 0, 0, 2'b00, 0, 3'b000, 0, 1, IDLE, 1);
    vecs[11] = mk(1, 0, 0, 2'b00, 9, 3'b001, 0, 1, IDLE, 1);
    vecs[12] = mk(1, 0, 9, 2'b01, 0, 3'b100, 1, 1, 13'b00010_0000_0000, 1);
    vecs[13] = mk(1, 0, 9, 2'b01, 0, 3'b100, 1, 1, 13'b11100_0010_0010, 2);
    vecs[14] = mk(1, 0, 0, 2'b00, 4, 3'b011, 0, 1, IDLE, 2);
    vecs[15] = mk(0, 0, 0, 2'b00, 0, 3'b000, 0, 1, IDLE, 2);
    vecs[16] = mk(1, 4, 0, 2'b10, 0, 3'b100, 0, 1, 13'b00010_1000_1000, 2);
    vecs[17] = mk(1, 4, 0, 2'b10, 0, 3'b100, 0, 1, 13'b11000_0100_0100, 3);

    seq[0] = mk(1, 0, 0,  2'b00, 12, 3'b001, 0, 1, IDLE, 0);
    seq[1] = mk(1, 0, 0,  2'b00, 0,  3'b000, 0, 1, IDLE, 0);
    seq[2] = mk(0, 0, 0,  2'b00, 0,  3'b000, 0, 1, IDLE, 0);
    seq[3] = mk(1, 0, 12, 2'b01, 10, 3'b001, 0, 0, 13'b00001_0001_0001, 0);
    seq[4] = mk(1, 0, 12, 2'b01, 10, 3'b001, 0, 0, 13'b00001_0001_0001, 1);
    seq[5] = mk(1, 0, 12, 2'b01, 10, 3'b001, 0, 0, 13'b00001_0001_0001, 2);
    seq[6] = mk(1, 0, 12, 2'b01, 10, 3'b001, 0, 1, 13'b11000_0001_0001, 3);

    rst = 1'b1;
    applyStimulus(1, {5'd1, 5'd2}, 2'b11, 5'd0, 3'b100, 1, 1);
    #2;
    checkOutput("reset_out", 32'(dut_out), 32'(IDLE));
    checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    pulseReset();
    for (int i = 0; i < 7; i++) runVec(seq[i], $sformatf("memwait%0d", i));
    runVec(mk(1, 0, 0, 2'b00, 0, 3'b000, 0, 1, IDLE, 3), "prehold_sw");
    runVec(mk(0, 0, 0, 2'b00, 0, 3'b000, 0, 1, IDLE, 3), "prehold_gap");

    applyStimulus(1, {5'd0, 5'd10}, 2'b01, 5'd11, 3'b001, 0, 0);
    #2;
    checkOutput("hold2_out", 32'(dut_out), 32'(13'b00001_0001_0001));
    checkOutput("hold2_cnt", 32'(stall_cnt), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("midhold_rst_out", 32'(dut_out), 32'(IDLE));
    checkOutput("midhold_rst_cnt", 32'(stall_cnt), 32'd0);
    nextCycle();
    rst = 1'b0;
    #2;
    checkOutput("post_rst_out", 32'(dut_out), 32'(IDLE));
    checkOutput("post_rst_cnt", 32'(stall_cnt), 32'd0);
    nextCycle();

    pulseReset();
    for (int s = 0; s < 3; s++) st[s] = '{v: 0, rd: 0, rw: 0, mr: 0, store: 0};
    mcnt = 0;
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                    2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ops[$urandom_range(0, 3)],
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
      #2;
      checkOutput("rand_cnt", 32'(stall_cnt), 32'(mcnt));
      modelStep(exp_o);
      checkOutput("rand_out", 32'(dut_out), 32'(exp_o));
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
